// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default widths for the register-file write scheduler.
package regfile_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREGS  = 32;

endpackage

// File: rtl/regfile_write_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer past the winner when the grant is consumed.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  input  logic            i_adv,
  output logic [NREQ-1:0] o_gnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_gidx;
  logic [NREQ-1:0]  w_gnt;
  logic             w_found;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NREQ) ? s - NREQ : s;
  endfunction

  always_comb begin
    w_gnt   = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (i_en && !w_found && i_req[wrap_idx(int'(r_ptr), off)]) begin
        w_found = 1'b1;
        w_gnt[wrap_idx(int'(r_ptr), off)] = 1'b1;
        w_gidx = PTR_W'(wrap_idx(int'(r_ptr), off));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (w_gidx == PTR_W'(NREQ - 1)) ? '0 : w_gidx + PTR_W'(1);
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler: zero sweep after reset, then round-robin
// sharing of the write port. ZERO_REG_PROTECT_EN suppresses run-time writes to register 0.
module regfile_write_sched
  import regfile_ctrl_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = DEF_NREGS
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0]      WrtAdd,
  output logic [DATA_W-1:0]      DIn,
  output logic                   Wenable,
  output logic                   init_done
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_init_done;
  logic [ADDR_W-1:0]   r_wrtadd;
  logic [DATA_W-1:0]   r_din;
  logic                r_wen;
  logic [NREQ-1:0]     w_gnt;
  logic                w_xfer;
  logic                w_wen_run;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic [DATA_W-1:0]   w_data_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_clk   (clk),
    .i_rst_n (Reset),
    .i_req   (req_valid),
    .i_en    (r_state == ST_RUN),
    .i_adv   (w_xfer),
    .o_gnt   (w_gnt)
  );

  assign w_xfer    = |w_gnt;
  assign req_ready = w_gnt;

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_cnt == ADDR_W'(NREGS - 1)) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_comb begin
    w_addr_sel = '0;
    w_data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_addr_sel = req_addr[i*ADDR_W +: ADDR_W];
        w_data_sel = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef ZERO_REG_PROTECT_EN
  // The handshake still completes; only the physical write is withheld.
  assign w_wen_run = w_xfer && (w_addr_sel != '0);
`else
  assign w_wen_run = w_xfer;
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
      if (r_state == ST_RUN) begin
        r_init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_wen    <= 1'b0;
      r_wrtadd <= '0;
      r_din    <= '0;
    end else if (r_state == ST_INIT) begin
      r_wen    <= 1'b1;
      r_wrtadd <= r_cnt;
      r_din    <= '0;
    end else begin
      r_wen <= w_wen_run;
      if (w_xfer) begin
        r_wrtadd <= w_addr_sel;
        r_din    <= w_data_sel;
      end
    end
  end

  assign WrtAdd    = r_wrtadd;
  assign DIn       = r_din;
  assign Wenable   = r_wen;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched with a behavioural 32x32 register file.
module tb_regfile_write_sched;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  logic                   clk = 1'b0;
  logic                   Reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [ADDR_W-1:0]      WrtAdd;
  logic [DATA_W-1:0]      DIn;
  logic                   Wenable;
  logic                   init_done;

  logic [DATA_W-1:0] rf [NREGS];
  int n_checks = 0;
  int n_errors = 0;

  regfile_write_sched #(
    .NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .WrtAdd    (WrtAdd),
    .DIn       (DIn),
    .Wenable   (Wenable),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (Wenable) rf[WrtAdd] <= DIn;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic sweep_check(input string tag);
    for (int n = 0; n < NREGS; n++) begin
      step();
      if (n == 20) req_valid = '0;
      chk({tag, "_wen"},   64'(Wenable),   64'(1));
      chk({tag, "_addr"},  64'(WrtAdd),    64'(n));
      chk({tag, "_din"},   64'(DIn),       64'(0));
      chk({tag, "_ready"}, 64'(req_ready), 64'(0));
      chk({tag, "_done"},  64'(init_done), 64'(0));
    end
    step();
    chk({tag, "_done_rise"}, 64'(init_done), 64'(1));
    chk({tag, "_wen_idle"},  64'(Wenable),   64'(0));
  endtask

  initial begin
    Reset     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    #3;
    chk("rst_wen",   64'(Wenable),   64'(0));
    chk("rst_addr",  64'(WrtAdd),    64'(0));
    chk("rst_din",   64'(DIn),       64'(0));
    chk("rst_done",  64'(init_done), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    step();
    step();
    // Requests during the sweep must be ignored.
    req_valid = 4'hF;
    Reset = 1'b1;
    sweep_check("sweep1");

    // Single write from requester 1
    set_req(1, 5'd5, 32'h78493052);
    req_valid = 4'b0010;
    #1 chk("w1_ready", 64'(req_ready), 64'(4'b0010));
    step();
    req_valid = '0;
    chk("w1_wen",  64'(Wenable), 64'(1));
    chk("w1_addr", 64'(WrtAdd),  64'(5));
    chk("w1_din",  64'(DIn),     64'(32'h78493052));
    step();
    chk("w1_wen_off",  64'(Wenable), 64'(0));
    chk("w1_addr_hold", 64'(WrtAdd), 64'(5));
    chk("w1_rf5",      64'(rf[5]),   64'(32'h78493052));

    // Pointer is 2; requester 0 wins by wrap-around, pointer becomes 1
    set_req(0, 5'd7, 32'h11111111);
    req_valid = 4'b0001;
    #1 chk("p0_ready", 64'(req_ready), 64'(4'b0001));
    step();
    chk("p0_addr", 64'(WrtAdd), 64'(7));

    // Requesters 0 and 2 with pointer 1: grant 2 then 0
    set_req(2, 5'd9, 32'h22222222);
    req_valid = 4'b0101;
    #1 chk("rr02_first", 64'(req_ready), 64'(4'b0100));
    step();
    chk("rr02_addr2", 64'(WrtAdd), 64'(9));
    chk("rr02_second", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    chk("rr02_addr0", 64'(WrtAdd), 64'(7));
    chk("rr02_din0",  64'(DIn),    64'(32'h11111111));

    // Requester 3 moves the pointer back to 0
    set_req(3, 5'd12, 32'h33333333);
    req_valid = 4'b1000;
    #1 chk("p3_ready", 64'(req_ready), 64'(4'b1000));
    step();
    req_valid = '0;

    // All four valid: rotation 0,1,2,3,0 with one write per cycle
    for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(16 + i), 32'hA0000000 + DATA_W'(i));
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1 chk("all_ready", 64'(req_ready), 64'(1 << (c % 4)));
      step();
      chk("all_wen",  64'(Wenable), 64'(1));
      chk("all_addr", 64'(WrtAdd),  64'(16 + (c % 4)));
      chk("all_din",  64'(DIn),     64'(32'hA0000000 + (c % 4)));
    end
    req_valid = '0;

    // Single requester held valid is granted every cycle
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1 chk("solo_ready", 64'(req_ready), 64'(4'b0100));
      step();
      chk("solo_wen", 64'(Wenable), 64'(1));
    end
    req_valid = '0;

    // Write to register 0
    set_req(0, 5'd0, 32'h73245243);
    req_valid = 4'b0001;
    #1 chk("z_ready", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
`ifdef ZERO_REG_PROTECT_EN
    chk("z_wen", 64'(Wenable), 64'(0));
    step();
    chk("z_rf0", 64'(rf[0]), 64'(0));
`else
    chk("z_wen", 64'(Wenable), 64'(1));
    step();
    chk("z_rf0", 64'(rf[0]), 64'(32'h73245243));
`endif

    // Reset from run, sweep to address 10, reset again mid-sweep
    Reset = 1'b0;
    #1 chk("rrun_done", 64'(init_done), 64'(0));
    step();
    Reset = 1'b1;
    for (int n = 0; n <= 10; n++) step();
    chk("mid_addr", 64'(WrtAdd),  64'(10));
    chk("mid_wen",  64'(Wenable), 64'(1));
    Reset = 1'b0;
    #1;
    chk("mid_rst_wen",  64'(Wenable),   64'(0));
    chk("mid_rst_addr", 64'(WrtAdd),    64'(0));
    chk("mid_rst_din",  64'(DIn),       64'(0));
    chk("mid_rst_done", 64'(init_done), 64'(0));
    step();
    chk("mid_rst_hold", 64'(Wenable), 64'(0));
    Reset = 1'b1;
    sweep_check("sweep2");
    chk("sweep2_rf5", 64'(rf[5]), 64'(0));
    chk("sweep2_rf0", 64'(rf[0]), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the 32×32-bit register file. Shares the file's single write port (DIn/WrtAdd/Wenable) among NREQ requesters using round-robin arbitration and a valid/ready handshake. After every reset it first sweeps the file, writing zero to every register. It sits between the datapath units that produce results and the register file's write port; read ports are not touched.

## Interface
- NREQ, 4: number of write requesters (2..8)
- DATA_W, 32: data width
- ADDR_W, 5: register address width
- NREGS, 32: registers swept during init (≤ 2**ADDR_W)
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester grant; transfer when valid&ready
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
- WrtAdd  out  ADDR_W  to register file, registered
- DIn  out  DATA_W  to register file, registered
- Wenable  out  1  to register file, registered, 1-cycle pulse per write
- init_done  out  1  high once the zero sweep has completed

## Operation
- FSM with 2 states: ST_INIT → ST_RUN. Reset forces ST_INIT.
- ST_INIT:
  - Sweep counter runs 0..NREGS-1, one address per cycle, issuing Wenable=1, WrtAdd=counter, DIn=0.
  - req_ready stays all-0.
  - After issuing address NREGS-1, go to ST_RUN and set init_done=1. init_done stays 1 until the next reset.
- ST_RUN, arbitration:
  - Among asserted req_valid bits, grant the first index at or after rr_ptr, wrapping modulo NREQ.
  - Exactly one req_ready is high, and only for that index. req_ready is combinational from req_valid, rr_ptr and state.
  - On a transfer to index g: rr_ptr ← (g+1) mod NREQ.
  - No transfer: rr_ptr unchanged.
  - A requester must hold valid/addr/data stable until its transfer. Dropping valid early is permitted and causes no write.
- Output register:
  - A transfer at edge k loads WrtAdd/DIn from the granted requester and sets Wenable=1 for the cycle after edge k.
  - With no transfer, Wenable=0 and WrtAdd/DIn hold their last values.
- Throughput: one write per cycle. Back-to-back grants to different requesters are allowed.
- Reset values: state=ST_INIT, sweep counter=0, rr_ptr=0, Wenable=0, WrtAdd=0, DIn=0, init_done=0, req_ready=0.

## Timing
- Reset deasserted before edge 0 → sweep writes address n at edge n+1. The first transfer can occur at edge NREGS; init_done is high from edge NREGS.
- Handshake at edge k → Wenable high during cycle k..k+1 → register file writes at edge k+1 → value readable on DataA/DataB after edge k+1.
- Reset asserted mid-sweep or mid-run: all outputs return to reset values immediately. A pending Wenable is dropped. The sweep restarts from 0 after deassertion.
- All requesters valid continuously: grants rotate 0,1,…,NREQ-1,0,… with one per cycle.
- Single requester valid continuously: it is granted every cycle.

## Configuration
- ZERO_REG_PROTECT_EN
  - Defined: in ST_RUN, a transfer with addr==0 still completes (ready is asserted and rr_ptr advances) but Wenable stays 0, so register 0 remains zero. The init sweep still writes address 0.
  - Undefined: address 0 is written like any other address.

## Structure
- Shared package regfile_ctrl_pkg:
  - State enum {ST_INIT, ST_RUN}
  - Default width constants: DATA_W=32, ADDR_W=5, NREGS=32
- Sub-module rr_arbiter:
  - Parameterized by NREQ.
  - Inputs: req vector, enable, advance strobe. Output: one-hot grant.
  - Owns rr_ptr.
- Top level holds the FSM, sweep counter, packed-bus mux and output register.

## Test plan
- Reset release, no requests → Wenable high for 32 consecutive cycles, WrtAdd 0..31, DIn=0. init_done rises at edge 32. req_ready=0 throughout the sweep.
- After init, requester 1 writes addr 5 data 32'h78493052 → Wenable=1, WrtAdd=5, DIn=32'h78493052 one cycle after the handshake. The register file reads back 32'h78493052 on the next cycle.
- All 4 requesters continuously valid → grant order 0,1,2,3,0 on consecutive edges; one Wenable per cycle.
- Requesters 0 and 2 valid, rr_ptr=1 → grant 2 first, then 0.
- Reset pulsed at sweep address 10 → outputs go to 0 immediately; the sweep restarts at address 0 and init_done remains 0 until 32 more writes.
- With ZERO_REG_PROTECT_EN, write addr 0 data 32'h73245243 → ready asserted, Wenable stays 0, register 0 reads 0. Without the macro, register 0 reads 32'h73245243.
